// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// the per-stage en/clear bundle with its canned patterns.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] HZ_RUN      = 2'd0;
  localparam logic [1:0] HZ_MEM_WAIT = 2'd1;
  localparam logic [1:0] HZ_MC_WAIT  = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic exmem_clr;
    logic memwb_en;
    logic memwb_clr;
  } stage_ctrl_t;

  // Field order: pc | ifid en,clr | idex en,clr | exmem en,clr | memwb en,clr
  localparam stage_ctrl_t CTL_FLOW  = 9'b1_10_10_10_10;
  localparam stage_ctrl_t CTL_FLUSH = 9'b1_11_11_10_10;
  localparam stage_ctrl_t CTL_LU    = 9'b0_00_11_10_10;
  localparam stage_ctrl_t CTL_MC    = 9'b0_00_00_11_10;
  localparam stage_ctrl_t CTL_MEM   = 9'b0_00_00_00_11;
  localparam stage_ctrl_t CTL_TMO   = 9'b0_11_11_11_11;
  localparam stage_ctrl_t CTL_RST   = 9'b0_01_01_01_01;

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating bus-wait counter: start loads 1, inc counts up, clr zeroes.
// expired is high while the count sits at MAX.
module hazard_wait_timer #(
  parameter int MAX = 255
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic start,
  input  logic inc,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                         cnt_q <= '0;
    else if (clr)                         cnt_q <= '0;
    else if (start)                       cnt_q <= W'(1);
    else if (inc && cnt_q != W'(MAX))     cnt_q <= cnt_q + 1'b1;
  end

  assign expired = (cnt_q == W'(MAX));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage-reg en/clear, PC enable, bus watchdog.
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [REG_ADDR_W-1:0] i_ID_Rs1,
  input  logic [REG_ADDR_W-1:0] i_ID_Rs2,
  input  logic                  i_ID_UsesRs1,
  input  logic                  i_ID_UsesRs2,
  input  logic [REG_ADDR_W-1:0] i_EX_Rd,
  input  logic                  i_EX_MemRead,
  input  logic                  i_EX_BranchTkn,
  input  logic                  i_EX_McStart,
  input  logic                  i_MC_Done,
  input  logic                  i_MEM_Req,
  input  logic                  i_MEM_Ack,
  output logic                  o_PC_En,
  output logic                  o_IFID_En,
  output logic                  o_IFID_Clear,
  output logic                  o_IDEX_En,
  output logic                  o_IDEX_Clear,
  output logic                  o_EXMEM_En,
  output logic                  o_EXMEM_Clear,
  output logic                  o_MEMWB_En,
  output logic                  o_MEMWB_Clear,
  output logic                  o_BusTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] o_StallCycles,
  output logic [STALL_CNT_W-1:0] o_FlushCount
`endif
);

  typedef logic [STALL_CNT_W-1:0] perf_cnt_t;

  logic [1:0]  state_q, state_d;
  stage_ctrl_t ctl, run_ctl;
  logic [1:0]  run_nxt;
  logic        load_use, tmr_start, tmr_inc, tmr_clr, tmr_expired, timeout;

  assign load_use = i_EX_MemRead && (i_EX_Rd != '0) &&
                    ((i_ID_UsesRs1 && i_ID_Rs1 == i_EX_Rd) ||
                     (i_ID_UsesRs2 && i_ID_Rs2 == i_EX_Rd));

  // RUN decision with the bus-freeze rule removed; shared by RUN and the Ack
  // cycle of MEM_WAIT so a released bus sees the same hazards as a free one.
  always_comb begin
    run_ctl = CTL_FLOW;
    run_nxt = HZ_RUN;
    if (i_EX_McStart) begin
      run_ctl = CTL_MC;
      run_nxt = HZ_MC_WAIT;
    end else if (i_EX_BranchTkn) run_ctl = CTL_FLUSH;
    else if (load_use)           run_ctl = CTL_LU;
  end

  always_comb begin
    ctl       = CTL_FLOW;
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_inc   = 1'b0;
    tmr_clr   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (i_MEM_Req && !i_MEM_Ack) begin
          ctl       = CTL_MEM;
          state_d   = HZ_MEM_WAIT;
          tmr_start = 1'b1;
        end else begin
          ctl     = run_ctl;
          state_d = run_nxt;
        end
      end
      HZ_MEM_WAIT: begin
        if (i_MEM_Ack) begin
          ctl     = run_ctl;
          state_d = run_nxt;
          tmr_clr = 1'b1;
        end else if (tmr_expired) begin
          ctl     = CTL_TMO;
          timeout = 1'b1;
          state_d = HZ_RUN;
          tmr_clr = 1'b1;
        end else begin
          ctl     = CTL_MEM;
          tmr_inc = 1'b1;
        end
      end
      HZ_MC_WAIT: begin
        if (i_MC_Done) begin
          ctl     = CTL_FLOW;
          state_d = HZ_RUN;
        end else ctl = CTL_MC;
      end
      default: state_d = HZ_RUN;
    endcase
    if (!i_Rst_n) begin
      ctl     = CTL_RST;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= HZ_RUN;
    else          state_q <= state_d;
  end

  hazard_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .start   (tmr_start),
    .inc     (tmr_inc),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  assign o_PC_En       = ctl.pc_en;
  assign o_IFID_En     = ctl.ifid_en;
  assign o_IFID_Clear  = ctl.ifid_clr;
  assign o_IDEX_En     = ctl.idex_en;
  assign o_IDEX_Clear  = ctl.idex_clr;
  assign o_EXMEM_En    = ctl.exmem_en;
  assign o_EXMEM_Clear = ctl.exmem_clr;
  assign o_MEMWB_En    = ctl.memwb_en;
  assign o_MEMWB_Clear = ctl.memwb_clr;
  assign o_BusTimeout  = timeout;

`ifdef HAZARD_PERF_CNT_EN
  perf_cnt_t stall_q, flush_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctl.pc_en)         stall_q <= stall_q + 1'b1;
      if (ctl == CTL_FLUSH)   flush_q <= flush_q + 1'b1;
    end
  end

  assign o_StallCycles = stall_q;
  assign o_FlushCount  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level behavioural model;
// covers HAZARD_PERF_CNT_EN builds too.
module tb_hazard_ctrl;
  localparam int TMO = 4;
  localparam logic [1:0] HOLD = 2'd0, LOAD = 2'd1, CLR = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mem_read, br, mc_start, mc_done, req, ack;
  logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic       exmem_en, exmem_clr, memwb_en, memwb_clr, bus_to;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TMO), .STALL_CNT_W(32)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_ID_Rs1(rs1), .i_ID_Rs2(rs2), .i_ID_UsesRs1(u1), .i_ID_UsesRs2(u2),
    .i_EX_Rd(rd), .i_EX_MemRead(mem_read), .i_EX_BranchTkn(br),
    .i_EX_McStart(mc_start), .i_MC_Done(mc_done),
    .i_MEM_Req(req), .i_MEM_Ack(ack),
    .o_PC_En(pc_en), .o_IFID_En(ifid_en), .o_IFID_Clear(ifid_clr),
    .o_IDEX_En(idex_en), .o_IDEX_Clear(idex_clr),
    .o_EXMEM_En(exmem_en), .o_EXMEM_Clear(exmem_clr),
    .o_MEMWB_En(memwb_en), .o_MEMWB_Clear(memwb_clr),
    .o_BusTimeout(bus_to)
`ifdef HAZARD_PERF_CNT_EN
    , .o_StallCycles(stall_cycles), .o_FlushCount(flush_count)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What a stage reg does this cycle: clear beats enable.
  function automatic logic [1:0] act(input logic en, input logic clr);
    return clr ? CLR : (en ? LOAD : HOLD);
  endfunction

  // Model: bus cycles waited so far (0 = bus not stalling), mul/div busy flag.
  int m_wait = 0;
  bit m_mc = 1'b0;
  int m_stall = 0, m_flush = 0;

  task automatic step(input string tag);
    logic [9:0] got, exp;
    logic lu;
    #1;
    got = {pc_en, act(ifid_en, ifid_clr), act(idex_en, idex_clr),
           act(exmem_en, exmem_clr), act(memwb_en, memwb_clr), bus_to};
    lu = mem_read && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!rst_n) begin
      exp = {1'b0, CLR, CLR, CLR, CLR, 1'b0};
      m_wait = 0; m_mc = 0; m_stall = 0; m_flush = 0;
    end else if (m_mc) begin
      if (mc_done) begin exp = {1'b1, LOAD, LOAD, LOAD, LOAD, 1'b0}; m_mc = 0; end
      else exp = {1'b0, HOLD, HOLD, CLR, LOAD, 1'b0};
    end else if (m_wait > 0 && !ack && m_wait == TMO) begin
      exp = {1'b0, CLR, CLR, CLR, CLR, 1'b1};
      m_wait = 0;
    end else if (m_wait > 0 && !ack) begin
      exp = {1'b0, HOLD, HOLD, HOLD, CLR, 1'b0};
      m_wait++;
    end else if (m_wait == 0 && req && !ack) begin
      exp = {1'b0, HOLD, HOLD, HOLD, CLR, 1'b0};
      m_wait = 1;
    end else begin
      m_wait = 0;
      if (mc_start) begin exp = {1'b0, HOLD, HOLD, CLR, LOAD, 1'b0}; m_mc = 1; end
      else if (br) begin exp = {1'b1, CLR, CLR, LOAD, LOAD, 1'b0}; m_flush++; end
      else if (lu) exp = {1'b0, HOLD, CLR, LOAD, LOAD, 1'b0};
      else         exp = {1'b1, LOAD, LOAD, LOAD, LOAD, 1'b0};
    end
    if (rst_n && !exp[9]) m_stall++;
    chk(tag, 32'(got), 32'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mem_read = 0; br = 0;
    mc_start = 0; mc_done = 0; req = 0; ack = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    step("reset0"); step("reset1");
    rst_n = 1'b1;
    step("run_idle");
    // load-use: lw x5 in EX, add x6,x5,x1 in ID, then the bubble
    mem_read = 1; rd = 5; rs1 = 5; rs2 = 1; u1 = 1; u2 = 1;
    step("lu_stall");
    mem_read = 0; rd = 0;
    step("lu_release");
    // x0 destination and non-load producers never stall
    mem_read = 1; rd = 0; rs1 = 0; step("lu_x0");
    mem_read = 0; rd = 5; rs1 = 5; step("lu_nonload");
    // branch beats load-use
    mem_read = 1; br = 1; step("br_over_lu");
    idle();
    // bus wait released by Ack on the 4th cycle
    req = 1; step("mem_w1"); step("mem_w2"); step("mem_w3");
    ack = 1; step("mem_ack");
    idle(); step("mem_after");
    // bus watchdog
    req = 1;
    for (int i = 0; i <= TMO; i++) step("mem_tmo");
    idle(); step("tmo_after");
    // mul/div wait aborted by reset
    mc_start = 1; step("mc_start");
    mc_start = 0;
    for (int i = 0; i < 4; i++) step("mc_wait");
    rst_n = 0; step("mc_rst");
    rst_n = 1; step("mc_rst_run");
    mc_start = 1; step("mc_start2");
    mc_start = 0; step("mc_wait2");
    mc_done = 1; step("mc_done");
    idle();

    for (int c = 0; c < 3000; c++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom);
      mem_read = ($urandom_range(0, 2) == 0);
      br       = ($urandom_range(0, 4) == 0);
      mc_start = ($urandom_range(0, 7) == 0);
      mc_done  = m_mc ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
      req      = (m_wait > 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
      ack      = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      step("rand");
    end

`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cycles, 32'(m_stall));
    chk("flush_cnt", flush_count, 32'(m_flush));
`endif
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
